uart_mmio_fifo: RTL and testbench

- Byte buffer between the CPU memory stage's UART MMIO accesses (0x80000000 control, 0x80000004 RX data, 0x80000008 TX data) and the on-chip uart block.
- TX FIFO absorbs CPU store bursts faster than the baud rate. RX FIFO holds received bytes until the CPU issues a load.
- Both FIFOs are first-word-fall-through. The CPU-side status bits replace the raw uart ready/valid in the control word.

---
 rtl/uart_mmio_fifo_if.sv | 49 ++++
 rtl/uart_mmio_fifo.sv | 118 +++++++++++
 tb/tb_uart_mmio_fifo.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_fifo_if.sv
// CPU-side and uart-side signal bundle for the UART MMIO byte FIFO.
// The loopback control exists only when UART_FIFO_LOOPBACK_EN is defined.
interface uart_mmio_fifo_if #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
);
  logic             tx_wr_en;
  logic [7:0]       tx_wr_data;
  logic             tx_full;
  logic             rx_rd_en;
  logic [7:0]       rx_rd_data;
  logic             rx_valid;
  logic [PTR_W:0]   tx_count;
  logic [PTR_W:0]   rx_count;
  logic             tx_overflow;
  logic             rx_overflow;
  logic             status_clr;
  logic [7:0]       uart_tx_data;
  logic             uart_tx_valid;
  logic             uart_tx_ready;
  logic [7:0]       uart_rx_data;
  logic             uart_rx_valid;
  logic             uart_rx_ready;
`ifdef UART_FIFO_LOOPBACK_EN
  logic             loopback;
`endif

  // FIFO block side
  modport slave (
    input  tx_wr_en, tx_wr_data, rx_rd_en, status_clr,
    input  uart_tx_ready, uart_rx_data, uart_rx_valid,
`ifdef UART_FIFO_LOOPBACK_EN
    input  loopback,
`endif
    output tx_full, rx_rd_data, rx_valid, tx_count, rx_count,
    output tx_overflow, rx_overflow, uart_tx_data, uart_tx_valid, uart_rx_ready
  );

  // CPU / uart / bench side
  modport master (
    output tx_wr_en, tx_wr_data, rx_rd_en, status_clr,
    output uart_tx_ready, uart_rx_data, uart_rx_valid,
`ifdef UART_FIFO_LOOPBACK_EN
    output loopback,
`endif
    input  tx_full, rx_rd_data, rx_valid, tx_count, rx_count,
    input  tx_overflow, rx_overflow, uart_tx_data, uart_tx_valid, uart_rx_ready
  );
endinterface

// File: rtl/uart_mmio_fifo.sv
// First-word-fall-through TX/RX byte FIFOs between the CPU UART MMIO accesses and the uart.
// Optional TX->RX loopback path is enabled by defining UART_FIFO_LOOPBACK_EN.
module uart_mmio_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_mmio_fifo_if.slave   bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [7:0]       tx_mem [DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr;
  logic [PTR_W-1:0] tx_rd_ptr;
  logic [PTR_W:0]   tx_cnt;
  logic             tx_ovf;

  logic [7:0]       rx_mem [DEPTH];
  logic [PTR_W-1:0] rx_wr_ptr;
  logic [PTR_W-1:0] rx_rd_ptr;
  logic [PTR_W:0]   rx_cnt;
  logic             rx_ovf;

  logic tx_empty, tx_full_int, rx_empty, rx_full_int;
  logic [7:0] tx_head;
  logic tx_pop, tx_push, tx_drop;
  logic rx_pop, rx_push, rx_drop;
  logic rx_in_valid;
  logic [7:0] rx_in_data;
  logic tx_to_uart;

  assign tx_empty    = (tx_cnt == '0);
  assign tx_full_int = (tx_cnt == FULL_CNT);
  assign rx_empty    = (rx_cnt == '0);
  assign rx_full_int = (rx_cnt == FULL_CNT);
  assign tx_head     = tx_mem[tx_rd_ptr];

`ifdef UART_FIFO_LOOPBACK_EN
  logic lb_move;

  // In loopback the TX head only moves when RX has room, so loopback never drops a byte.
  assign lb_move     = bus.loopback && !tx_empty && !rx_full_int;
  assign tx_to_uart  = !tx_empty && !bus.loopback;
  assign tx_pop      = lb_move || (tx_to_uart && bus.uart_tx_ready);
  assign rx_in_valid = bus.loopback ? lb_move : bus.uart_rx_valid;
  assign rx_in_data  = bus.loopback ? tx_head : bus.uart_rx_data;
`else
  assign tx_to_uart  = !tx_empty;
  assign tx_pop      = tx_to_uart && bus.uart_tx_ready;
  assign rx_in_valid = bus.uart_rx_valid;
  assign rx_in_data  = bus.uart_rx_data;
`endif

  // A pop in the same cycle frees the slot, so a write into a full FIFO is accepted then.
  assign tx_push = bus.tx_wr_en && (!tx_full_int || tx_pop);
  assign tx_drop = bus.tx_wr_en && tx_full_int && !tx_pop;

  assign rx_pop  = bus.rx_rd_en && !rx_empty;
  assign rx_push = rx_in_valid && (!rx_full_int || rx_pop);
  assign rx_drop = rx_in_valid && rx_full_int && !rx_pop;

  // Control state: pointers, occupancy and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
      tx_ovf    <= 1'b0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
      rx_ovf    <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase

      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase

      // A drop in the same cycle as a clear keeps the flag set
      if (tx_drop)             tx_ovf <= 1'b1;
      else if (bus.status_clr) tx_ovf <= 1'b0;
      if (rx_drop)             rx_ovf <= 1'b1;
      else if (bus.status_clr) rx_ovf <= 1'b0;
    end
  end

  // Storage: contents are not reset, emptiness is tracked by the counts
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.tx_wr_data;
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_in_data;
  end

  assign bus.tx_full       = tx_full_int;
  assign bus.tx_count      = tx_cnt;
  assign bus.tx_overflow   = tx_ovf;
  assign bus.uart_tx_valid = tx_to_uart;
  assign bus.uart_tx_data  = tx_empty ? 8'h00 : tx_head;

  assign bus.rx_valid      = !rx_empty;
  assign bus.rx_count      = rx_cnt;
  assign bus.rx_overflow   = rx_ovf;
  assign bus.rx_rd_data    = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
  assign bus.uart_rx_ready = 1'b1;

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Scoreboard bench for uart_mmio_fifo: stimulus queues expected bytes, monitors check them on handshakes.
module tb_uart_mmio_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_mmio_fifo_if #(.DEPTH(8)) bus ();

  uart_mmio_fifo #(.DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // TX monitor: every byte the uart accepts must match the oldest queued CPU write
  always @(negedge clk) begin
    if (rst_n && bus.uart_tx_valid && bus.uart_tx_ready) begin
      if (tx_exp.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_unexpected: got 0x%0h, expected no byte", bus.uart_tx_data);
      end else begin
        check("tx_data", 32'(bus.uart_tx_data), 32'(tx_exp.pop_front()));
      end
    end
  end

  // RX monitor: every CPU pop must return the oldest queued received byte
  always @(negedge clk) begin
    if (rst_n && bus.rx_rd_en && bus.rx_valid) begin
      if (rx_exp.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx_unexpected: got 0x%0h, expected no byte", bus.rx_rd_data);
      end else begin
        check("rx_data", 32'(bus.rx_rd_data), 32'(rx_exp.pop_front()));
      end
    end
  end

  initial begin
    bus.tx_wr_en      = 1'b0;
    bus.tx_wr_data    = 8'h00;
    bus.rx_rd_en      = 1'b0;
    bus.status_clr    = 1'b0;
    bus.uart_tx_ready = 1'b0;
    bus.uart_rx_data  = 8'h00;
    bus.uart_rx_valid = 1'b0;
`ifdef UART_FIFO_LOOPBACK_EN
    bus.loopback      = 1'b0;
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset then idle
    check("rst_tx_count", 32'(bus.tx_count), 32'd0);
    check("rst_rx_count", 32'(bus.rx_count), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_tx_valid", 32'(bus.uart_tx_valid), 32'd0);
    check("rst_tx_full", 32'(bus.tx_full), 32'd0);
    check("rst_tx_ovf", 32'(bus.tx_overflow), 32'd0);
    check("rst_rx_ovf", 32'(bus.rx_overflow), 32'd0);
    check("rst_rx_data", 32'(bus.rx_rd_data), 32'd0);
    check("rst_rx_ready", 32'(bus.uart_rx_ready), 32'd1);

    // Three writes held back, then drained one per cycle
    for (int i = 0; i < 3; i++) begin
      bus.tx_wr_en   = 1'b1;
      bus.tx_wr_data = 8'h41 + 8'(i);
      tx_exp.push_back(8'h41 + 8'(i));
      tick();
    end
    bus.tx_wr_en = 1'b0;
    check("burst_valid", 32'(bus.uart_tx_valid), 32'd1);
    check("burst_head", 32'(bus.uart_tx_data), 32'h41);
    bus.uart_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_count", 32'(bus.tx_count), 32'(3 - i));
    end
    tick();
    bus.uart_tx_ready = 1'b0;

    // Overfill TX: ninth byte dropped
    for (int i = 0; i < 9; i++) begin
      bus.tx_wr_en   = 1'b1;
      bus.tx_wr_data = 8'(i);
      if (i < 8) tx_exp.push_back(8'(i));
      tick();
      if (i == 7) check("full_after_8", 32'(bus.tx_full), 32'd1);
    end
    bus.tx_wr_en = 1'b0;
    check("full_count", 32'(bus.tx_count), 32'd8);
    check("tx_ovf_set", 32'(bus.tx_overflow), 32'd1);
    bus.status_clr = 1'b1;
    tick();
    bus.status_clr = 1'b0;
    check("tx_ovf_clr", 32'(bus.tx_overflow), 32'd0);

    // Write and pop together while full
    bus.tx_wr_en      = 1'b1;
    bus.tx_wr_data    = 8'h5A;
    bus.uart_tx_ready = 1'b1;
    tx_exp.push_back(8'h5A);
    tick();
    bus.tx_wr_en = 1'b0;
    bus.uart_tx_ready = 1'b0;
    check("full_pushpop_count", 32'(bus.tx_count), 32'd8);
    check("full_pushpop_ovf", 32'(bus.tx_overflow), 32'd0);
    bus.uart_tx_ready = 1'b1;
    for (int i = 0; i < 20 && bus.tx_count != 0; i++) tick();
    bus.uart_tx_ready = 1'b0;
    check("tx_drained", 32'(bus.tx_count), 32'd0);
    check("tx_exp_empty", 32'(tx_exp.size()), 32'd0);

    // RX: two bytes, two pops, one pop while empty
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data  = 8'h55;
    rx_exp.push_back(8'h55);
    tick();
    bus.uart_rx_data  = 8'hAA;
    rx_exp.push_back(8'hAA);
    tick();
    bus.uart_rx_valid = 1'b0;
    check("rx_count2", 32'(bus.rx_count), 32'd2);
    check("rx_head", 32'(bus.rx_rd_data), 32'h55);
    bus.rx_rd_en = 1'b1;
    repeat (3) tick();
    bus.rx_rd_en = 1'b0;
    check("rx_empty_count", 32'(bus.rx_count), 32'd0);
    check("rx_empty_data", 32'(bus.rx_rd_data), 32'd0);
    check("rx_empty_valid", 32'(bus.rx_valid), 32'd0);

    // Fill RX, drop, set-wins-over-clear, then push with pop at full
    bus.uart_rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx_data = 8'h10 + 8'(i);
      rx_exp.push_back(8'h10 + 8'(i));
      tick();
    end
    bus.uart_rx_data = 8'h99;
    tick();
    check("rx_full_count", 32'(bus.rx_count), 32'd8);
    check("rx_ovf_set", 32'(bus.rx_overflow), 32'd1);
    bus.uart_rx_data = 8'h98;
    bus.status_clr   = 1'b1;
    tick();
    check("rx_ovf_setwins", 32'(bus.rx_overflow), 32'd1);
    bus.uart_rx_valid = 1'b0;
    tick();
    bus.status_clr = 1'b0;
    check("rx_ovf_clr", 32'(bus.rx_overflow), 32'd0);
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data  = 8'h77;
    bus.rx_rd_en      = 1'b1;
    rx_exp.push_back(8'h77);
    tick();
    bus.uart_rx_valid = 1'b0;
    bus.rx_rd_en      = 1'b0;
    check("rx_pushpop_count", 32'(bus.rx_count), 32'd8);
    check("rx_pushpop_ovf", 32'(bus.rx_overflow), 32'd0);
    bus.rx_rd_en = 1'b1;
    for (int i = 0; i < 20 && bus.rx_count != 0; i++) tick();
    bus.rx_rd_en = 1'b0;
    check("rx_drained", 32'(bus.rx_count), 32'd0);
    check("rx_exp_empty", 32'(rx_exp.size()), 32'd0);

    // Asynchronous reset with 5 TX bytes and 2 RX bytes buffered
    for (int i = 0; i < 5; i++) begin
      bus.tx_wr_en      = 1'b1;
      bus.tx_wr_data    = 8'hC0 + 8'(i);
      bus.uart_rx_valid = (i < 2);
      bus.uart_rx_data  = 8'hD0 + 8'(i);
      tick();
    end
    bus.tx_wr_en      = 1'b0;
    bus.uart_rx_valid = 1'b0;
    check("pre_rst_tx_count", 32'(bus.tx_count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_tx_count", 32'(bus.tx_count), 32'd0);
    check("async_rx_count", 32'(bus.rx_count), 32'd0);
    check("async_tx_valid", 32'(bus.uart_tx_valid), 32'd0);
    check("async_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("async_tx_data", 32'(bus.uart_tx_data), 32'd0);
    tick();
    rst_n = 1'b1;

    // First edge after release behaves normally
    bus.tx_wr_en   = 1'b1;
    bus.tx_wr_data = 8'h3C;
    tx_exp.push_back(8'h3C);
    tick();
    bus.tx_wr_en = 1'b0;
    check("post_rst_count", 32'(bus.tx_count), 32'd1);
    check("post_rst_head", 32'(bus.uart_tx_data), 32'h3C);
    bus.uart_tx_ready = 1'b1;
    tick();
    bus.uart_tx_ready = 1'b0;
    check("post_rst_drained", 32'(bus.tx_count), 32'd0);
    check("final_tx_exp", 32'(tx_exp.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
